demux_stream: RTL and testbench
===============================

Name: demux_stream

Overview:
- Parametrised, registered successor to the gate-level 1-to-4 demux: routes one input stream to one of N output channels, or to all of them (broadcast).
- Valid/ready handshake on input and on every output; each output channel has a one-entry output register.
- Sits between a single producer and N independent consumers; replaces the combinational demux wherever back-pressure is needed.

Parameters:
- WIDTH, 8, data bits per beat.
- SEL_W, 2, select width; channel count N = 2**SEL_W (derived, not overridable).
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; 0 blocks new input acceptance.
- in_valid  in  1  producer has a beat.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  WIDTH  input beat.
- sel  in  SEL_W  target channel; ignored when bcast=1.
- bcast  in  1  deliver the beat to all N channels.
- out_valid  out  N  per-channel valid; bit i belongs to channel i.
- out_ready  in  N  per-channel consumer ready.
- out_data  out  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- xfer_cnt  out  CNT_W  count of accepted input beats.

Behaviour:
- Reset (async assert, sync release): out_valid = 0, out_data = 0, xfer_cnt = 0. in_ready is combinational and is therefore 0 while rst=1.
- Slot i is free when !out_valid[i] || out_ready[i], i.e. empty, or draining this cycle.
- in_ready = en && !rst && (bcast ? all N slots free : slot[sel] free). Purely combinational from en, bcast, sel, out_valid and out_ready; it never depends on in_valid.
- Accept = in_valid && in_ready.
  - On accept, each targeted slot loads in_data and sets out_valid=1 at the next edge.
  - Latency: 1 cycle from accept to out_valid.
- Slot update at the edge, per channel:
  - load → data = in_data, valid = 1;
  - else if out_valid && out_ready → valid = 0, data held;
  - else hold.
  - Load and drain in the same cycle gives back-to-back throughput of 1 beat/cycle per channel.
- Broadcast is atomic: the beat is accepted only when all N slots are free. There is never a partial delivery. When any slot is busy, in_ready=0.
- Upstream rule: in_data, sel and bcast are held stable while in_valid=1 and in_ready=0. The bench asserts this rule; the block does not check it.
- Consumer rule: out_data[i] is stable while out_valid[i]=1 and out_ready[i]=0.
- Non-targeted channels are unaffected by an accept: their valid and data are unchanged.
- en=0: no new accepts. Occupied slots still drain normally.
- xfer_cnt increments by 1 per accept; a broadcast counts as 1. It wraps from 2**CNT_W-1 to 0 with no flag.
- Reset mid-operation: all pending beats are discarded immediately (async). No out_valid is emitted after reset deasserts until a new accept.
- The default configuration (SEL_W=2, always ready, no bcast) reproduces the legacy one-hot decoding:
  - {b,a} maps to sel;
  - en maps to en && in_valid;
  - delayed by one cycle.

Decomposition:
- Package demux_pkg:
  - default WIDTH/SEL_W/CNT_W constants;
  - function chan_slice(i) returning the out_data bit offset i*WIDTH.
- Sub-module demux_slot (WIDTH): one-entry register with load, drain and free outputs.
  - The top generates N instances.
  - The top also holds the select decode, the broadcast AND-reduce, the in_ready logic and xfer_cnt.

Test Plan:
- Sweep: out_ready=4'b1111, en=1, in_data=8'hA0+sel, sel 0→3 on consecutive cycles → each out_valid[sel] pulses one cycle later carrying 8'hA0+sel, and xfer_cnt=4.
- Back-pressure: out_ready[2]=0, send 8'h11 then 8'h22 to sel=2 → first accepted, then in_ready=0 with out_data[2]=8'h11 held. Raise out_ready[2] → 8'h22 accepted in that same cycle and appears next cycle.
- Broadcast stall: out_valid[1]=1 and out_ready[1]=0, bcast=1, in_data=8'h5A → in_ready=0 and no channel changes. Free channel 1 → all four out_valid=1 with 8'h5A next cycle; xfer_cnt increments by exactly 1.
- Enable gating: en=0, in_valid=1 for 5 cycles → in_ready=0, xfer_cnt unchanged, and previously loaded slots still drain.
- Async reset mid-stream: assert rst between edges while channels 0 and 3 are valid → out_valid=0, out_data=0 and xfer_cnt=0 immediately. After release, no out_valid until a new accept.
- Counter wrap: with CNT_W=4, 17 accepts → xfer_cnt=1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered stream demultiplexer.
package demux_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_SEL_W = 2;
  localparam int unsigned DEF_CNT_W = 16;

  // Bit offset of channel i inside the flattened out_data bus.
  function automatic int unsigned chan_slice(input int unsigned i, input int unsigned width);
    return i * width;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel.
module demux_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             free_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Load wins over drain so a full slot can take a new beat while emptying.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot state register; reset discards any pending beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  // Combinational: slot is empty or is being drained this cycle.
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demux with optional atomic broadcast.
module demux_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEL_W = DEF_SEL_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  input  logic [SEL_W-1:0]                sel,
  input  logic                            bcast,
  output logic [(1<<SEL_W)-1:0]           out_valid,
  input  logic [(1<<SEL_W)-1:0]           out_ready,
  output logic [(1<<SEL_W)*WIDTH-1:0]     out_data,
  output logic [CNT_W-1:0]                xfer_cnt
);

  localparam int unsigned N = 1 << SEL_W;

  logic [N-1:0]     free;
  logic [N-1:0]     load;
  logic [WIDTH-1:0] slot_data [N];
  logic             accept;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  // Handshake, target decode and counter next-state.
  always_comb begin
    in_ready   = en && !rst && (bcast ? (&free) : free[sel]);
    accept     = in_valid && in_ready;
    load       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      load[i] = accept && (bcast || (sel == SEL_W'(i)));
    end
    xfer_cnt_d = xfer_cnt_q + CNT_W'(accept);
  end

  // Accepted-beat counter; wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;

  for (genvar g = 0; g < N; g++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[g]),
      .data_i  (in_data),
      .ready_i (out_ready[g]),
      .valid_o (out_valid[g]),
      .data_o  (slot_data[g]),
      .free_o  (free[g])
    );
    assign out_data[chan_slice(g, WIDTH) +: WIDTH] = slot_data[g];
  end

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream against a per-channel queue-free reference model.
module tb_demux_stream;

  localparam int W  = 8;
  localparam int SW = 2;
  localparam int CW = 4;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] sel;
  logic          bcast;
  logic [NC-1:0] out_valid;
  logic [NC-1:0] out_ready;
  logic [NC*W-1:0] out_data;
  logic [CW-1:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: what each consumer should currently see, plus beat count.
  bit       m_valid [NC];
  bit [7:0] m_data  [NC];
  int       m_cnt;

  demux_stream #(.WIDTH(W), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sel(sel), .bcast(bcast), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // Producer rule: payload must stay put while a beat is stalled.
  logic          p_stall = 1'b0;
  logic [W-1:0]  p_data;
  logic [SW-1:0] p_sel;
  logic          p_bcast;
  always @(negedge clk) begin
    if (!rst && p_stall && in_valid &&
        (in_data !== p_data || sel !== p_sel || bcast !== p_bcast)) begin
      $display("FAIL upstream_stable: payload changed while stalled");
      errors <= errors + 1;
    end
    p_stall <= in_valid && !in_ready && !rst;
    p_data  <= in_data;
    p_sel   <= sel;
    p_bcast <= bcast;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      m_valid[c] = 1'b0;
      m_data[c]  = 8'h00;
    end
    m_cnt = 0;
  endtask

  // Evaluate one clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic step();
    bit all_free;
    bit exp_ready;
    bit acc;
    #2;
    all_free = 1'b1;
    for (int c = 0; c < NC; c++)
      if (m_valid[c] && !out_ready[c]) all_free = 1'b0;
    exp_ready = en && !rst && (bcast ? all_free : (!m_valid[sel] || out_ready[sel]));
    checks++;
    if (in_ready !== exp_ready) begin
      $display("FAIL in_ready: got %b expected %b (sel=%0d bcast=%b)", in_ready, exp_ready, sel, bcast);
      errors++;
    end
    acc = in_valid && exp_ready;
    for (int c = 0; c < NC; c++) begin
      if (acc && (bcast || int'(sel) == c)) begin
        m_valid[c] = 1'b1;
        m_data[c]  = in_data;
      end else if (out_ready[c]) begin
        m_valid[c] = 1'b0;
      end
    end
    if (acc) m_cnt = (m_cnt + 1) % (1 << CW);
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (out_valid[c] !== m_valid[c] || out_data[c*W +: W] !== m_data[c]) begin
        $display("FAIL chan%0d: got v=%b d=%h expected v=%b d=%h", c, out_valid[c],
                 out_data[c*W +: W], m_valid[c], m_data[c]);
        errors++;
      end
    end
    checks++;
    if (xfer_cnt !== CW'(m_cnt)) begin
      $display("FAIL xfer_cnt: got %0d expected %0d", xfer_cnt, m_cnt);
      errors++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_clear();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; sel = '0; bcast = 1'b0; out_ready = '1;
    @(posedge clk);
    #3;
    checks++;
    if (out_valid !== '0 || out_data !== '0 || xfer_cnt !== '0 || in_ready !== 1'b0) begin
      $display("FAIL reset_state: v=%b d=%h cnt=%0d rdy=%b expected all zero", out_valid, out_data, xfer_cnt, in_ready);
      errors++;
    end
    @(posedge clk);
    #1;
    model_clear();
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    out_ready = 4'b1111; en = 1'b1; bcast = 1'b0; in_valid = 1'b1;
    for (int s = 0; s < NC; s++) begin
      sel = SW'(s);
      in_data = 8'hA0 + 8'(s);
      step();
      checks++;
      if (out_valid !== 4'(1 << s) || out_data[s*W +: W] !== 8'hA0 + 8'(s)) begin
        $display("FAIL sweep_sel%0d: v=%b d=%h expected v=%b d=%h", s, out_valid,
                 out_data[s*W +: W], 4'(1 << s), 8'hA0 + 8'(s));
        errors++;
      end
    end
    checks++;
    if (xfer_cnt !== 4'd4) begin
      $display("FAIL sweep_cnt: got %0d expected 4", xfer_cnt);
      errors++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_pressure();
    out_ready = 4'b1011; sel = 2'd2; bcast = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    step();
    in_data = 8'h22;
    #2;
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL bp_stall_ready: got %b expected 0", in_ready);
      errors++;
    end
    step();
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[2*W +: W] !== 8'h11) begin
      $display("FAIL bp_hold: v=%b d=%h expected v=1 d=11", out_valid[2], out_data[2*W +: W]);
      errors++;
    end
    out_ready = 4'b1111;
    step();
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[2*W +: W] !== 8'h22) begin
      $display("FAIL bp_release: v=%b d=%h expected v=1 d=22", out_valid[2], out_data[2*W +: W]);
      errors++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_bcast_stall();
    int c0;
    out_ready = 4'b1101; bcast = 1'b0; sel = 2'd1; in_data = 8'h33; in_valid = 1'b1;
    step();
    bcast = 1'b1; in_data = 8'h5A;
    c0 = m_cnt;
    #2;
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL bcast_stall_ready: got %b expected 0", in_ready);
      errors++;
    end
    step();
    checks++;
    if (out_valid !== 4'b0010 || out_data[1*W +: W] !== 8'h33) begin
      $display("FAIL bcast_no_partial: v=%b d1=%h expected v=0010 d1=33", out_valid, out_data[1*W +: W]);
      errors++;
    end
    out_ready = 4'b1111;
    step();
    checks++;
    if (out_valid !== 4'b1111 || out_data !== {4{8'h5A}} || xfer_cnt !== CW'(c0 + 1)) begin
      $display("FAIL bcast_deliver: v=%b d=%h cnt=%0d expected v=1111 d=5a5a5a5a cnt=%0d",
               out_valid, out_data, xfer_cnt, (c0 + 1) % 16);
      errors++;
    end
    in_valid = 1'b0; bcast = 1'b0;
    step();
  endtask

  task automatic test_enable();
    int c0;
    out_ready = 4'b0000; en = 1'b1; bcast = 1'b0; in_valid = 1'b1;
    sel = 2'd0; in_data = 8'h77; step();
    sel = 2'd3; in_data = 8'h78; step();
    en = 1'b0; sel = 2'd1; in_data = 8'h99; out_ready = 4'b1111;
    c0 = m_cnt;
    for (int k = 0; k < 5; k++) begin
      #2;
      checks++;
      if (in_ready !== 1'b0) begin
        $display("FAIL en_gate_ready%0d: got %b expected 0", k, in_ready);
        errors++;
      end
      step();
    end
    checks++;
    if (out_valid !== 4'b0000 || xfer_cnt !== CW'(c0)) begin
      $display("FAIL en_gate_drain: v=%b cnt=%0d expected v=0000 cnt=%0d", out_valid, xfer_cnt, c0);
      errors++;
    end
    en = 1'b1; in_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 4'b0000; en = 1'b1; bcast = 1'b0; in_valid = 1'b1;
    sel = 2'd0; in_data = 8'hC0; step();
    sel = 2'd3; in_data = 8'hC3; step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b1001) begin
      $display("FAIL arst_setup: v=%b expected 1001", out_valid);
      errors++;
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== '0 || out_data !== '0 || xfer_cnt !== '0 || in_ready !== 1'b0) begin
      $display("FAIL arst_immediate: v=%b d=%h cnt=%0d rdy=%b expected all zero", out_valid, out_data, xfer_cnt, in_ready);
      errors++;
    end
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      out_ready = 4'($urandom_range(0, 15));
      step();
    end
    checks++;
    if (out_valid !== 4'b0000) begin
      $display("FAIL arst_no_ghost: v=%b expected 0000", out_valid);
      errors++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 4'b1111; en = 1'b1; bcast = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      sel = SW'($urandom_range(0, 3));
      in_data = 8'($urandom);
      step();
    end
    checks++;
    if (xfer_cnt !== 4'd1) begin
      $display("FAIL cnt_wrap: got %0d expected 1", xfer_cnt);
      errors++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    bit stalled;
    stalled = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        sel      = SW'($urandom_range(0, 3));
        bcast    = ($urandom_range(0, 7) == 0);
        in_data  = 8'($urandom);
      end
      en        = ($urandom_range(0, 9) != 0);
      out_ready = 4'($urandom_range(0, 15));
      #1;
      stalled = in_valid && !in_ready;
      #0;
      step();
    end
    in_valid = 1'b0; bcast = 1'b0; en = 1'b1;
    step();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_sweep();
    test_back_pressure();
    test_bcast_stall();
    test_enable();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
